// File: rtl/coproc_instr_sequencer.sv
// coproc_instr_sequencer
// Avalon-MM slave that queues coprocessor instructions written by the HPS and
// issues them one at a time over a cp_start/cp_done handshake. Contains a
// small instruction FIFO, a per-instruction watchdog, sticky status bits and
// a completion counter.
//
// Optional feature macro: COPROC_SEQ_IRQ_EN
//   defined   -> irq_en register at status[6], level irq from sticky bits
//   undefined -> irq tied low, status[6] reads 0 and ignores writes
//
// Register map (write strobe = chipselect & ~write_n):
//   0  W push instruction            R last issued instruction
//   1  W clear/flush/irq_en controls R status
//   2  RW watchdog limit (0 = off)
//   3  W clear                       R completed-instruction count

module coproc_instr_sequencer #(
  parameter int FIFO_DEPTH = 4,
  parameter int INSTR_W    = 6,
  parameter int TIMEOUT_W  = 16
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic [1:0]         address,
  input  logic               chipselect,
  input  logic               write_n,
  input  logic [31:0]        writedata,
  output logic [31:0]        readdata,
  output logic [INSTR_W-1:0] cp_instr,
  output logic               cp_start,
  input  logic               cp_done,
  output logic               irq
);

  localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_WAIT  = 2'd2;

  // Coprocessor handshake: cp_start is high for exactly one cycle while the
  // FSM sits in ISSUE, with cp_instr already stable and held until the next
  // issue. The coprocessor answers with a one-cycle cp_done pulse; cp_done
  // is only honoured in WAIT and ignored in every other state.

  logic [1:0]           state;
  logic [INSTR_W-1:0]   mem [FIFO_DEPTH];
  logic [PTR_W-1:0]     wr_ptr;
  logic [PTR_W-1:0]     rd_ptr;
  logic [CNT_W-1:0]     count;
  logic [TIMEOUT_W-1:0] wd_cnt;
  logic [TIMEOUT_W-1:0] wd_next;
  logic [TIMEOUT_W-1:0] limit;
  logic [15:0]          comp_cnt;
  logic                 err_overflow;
  logic                 err_timeout;
  logic                 done_sticky;
  logic                 irq_en_bit;

  logic wr_en;
  logic push_req;
  logic push_ok;
  logic overflow_set;
  logic flush;
  logic pop;
  logic fifo_full;
  logic fifo_empty;
  logic err_clr;
  logic done_clr;
  logic limit_wr;
  logic count_clr;
  logic done_evt;
  logic timeout_evt;

  logic [31:0] instr_ext;
  logic [31:0] limit_ext;
  logic [31:0] status;

  logic unused_wdata;
  assign unused_wdata = ^writedata;

  // Bus decode, FIFO control and FSM event qualification
  always_comb begin
    wr_en        = chipselect & ~write_n;
    fifo_full    = (count == DEPTH_C);
    fifo_empty   = (count == '0);
    flush        = wr_en && (address == 2'd1) && writedata[1];
    push_req     = wr_en && (address == 2'd0);
    // A full FIFO drops the push even if a pop frees a slot this cycle.
    push_ok      = push_req && !fifo_full && !flush;
    overflow_set = push_req && fifo_full;
    pop          = (state == S_IDLE) && !fifo_empty;
    err_clr      = wr_en && (address == 2'd1) && writedata[0];
    done_clr     = wr_en && (address == 2'd1) && writedata[5];
    limit_wr     = wr_en && (address == 2'd2);
    count_clr    = wr_en && (address == 2'd3);
    wd_next      = wd_cnt + TIMEOUT_W'(1);
    done_evt     = (state == S_WAIT) && cp_done;
    // Expiry fires on the edge where the counter reaches the limit; a
    // simultaneous cp_done takes priority.
    timeout_evt  = (state == S_WAIT) && !cp_done && (limit != '0) &&
                   (wd_next == limit);
  end

  assign cp_start = (state == S_ISSUE);

  // FIFO storage; contents need no reset since count gates every read
  always_ff @(posedge clk) begin
    if (push_ok) mem[wr_ptr] <= writedata[INSTR_W-1:0];
  end

  // FIFO pointers and occupancy; flush only clears the queue, never the FSM
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)     rd_ptr <= rd_ptr + PTR_W'(1);
      if (push_ok && !pop)      count <= count + CNT_W'(1);
      else if (!push_ok && pop) count <= count - CNT_W'(1);
    end
  end

  // Issue FSM: IDLE pops the head, ISSUE pulses cp_start, WAIT runs watchdog
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      cp_instr <= '0;
      wd_cnt   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (pop) begin
            cp_instr <= mem[rd_ptr];
            state    <= S_ISSUE;
          end
        end
        S_ISSUE: begin
          wd_cnt <= '0;
          state  <= S_WAIT;
        end
        S_WAIT: begin
          wd_cnt <= wd_next;
          if (done_evt || timeout_evt) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Sticky error/done bits: a set event beats a clear in the same cycle
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      err_overflow <= 1'b0;
      err_timeout  <= 1'b0;
      done_sticky  <= 1'b0;
    end else begin
      if (overflow_set) err_overflow <= 1'b1;
      else if (err_clr) err_overflow <= 1'b0;
      if (timeout_evt)  err_timeout  <= 1'b1;
      else if (err_clr) err_timeout  <= 1'b0;
      if (done_evt)      done_sticky <= 1'b1;
      else if (done_clr) done_sticky <= 1'b0;
    end
  end

  // Watchdog limit and wrapping completion counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      limit    <= '0;
      comp_cnt <= '0;
    end else begin
      if (limit_wr) limit <= writedata[TIMEOUT_W-1:0];
      if (count_clr)     comp_cnt <= '0;
      else if (done_evt) comp_cnt <= comp_cnt + 16'd1;
    end
  end

`ifdef COPROC_SEQ_IRQ_EN
  logic irq_en_q;

  // Interrupt enable, loaded by any write to the status register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                           irq_en_q <= 1'b0;
    else if (wr_en && (address == 2'd1))    irq_en_q <= writedata[6];
  end

  assign irq_en_bit = irq_en_q;
  assign irq        = irq_en_q & (done_sticky | err_overflow | err_timeout);
`else
  assign irq_en_bit = 1'b0;
  assign irq        = 1'b0;
`endif

  // Zero-latency read mux over registered state
  always_comb begin
    instr_ext = '0;
    instr_ext[INSTR_W-1:0] = cp_instr;
    limit_ext = '0;
    limit_ext[TIMEOUT_W-1:0] = limit;
    status = '0;
    status[0] = (state != S_IDLE);
    status[1] = fifo_empty;
    status[2] = fifo_full;
    status[3] = err_overflow;
    status[4] = err_timeout;
    status[5] = done_sticky;
    status[6] = irq_en_bit;
    status[8 +: CNT_W] = count;
    case (address)
      2'd0:    readdata = instr_ext;
      2'd1:    readdata = status;
      2'd2:    readdata = limit_ext;
      default: readdata = {16'd0, comp_cnt};
    endcase
  end

endmodule

// File: tb/tb_coproc_instr_sequencer.sv
// Directed bench for coproc_instr_sequencer: a per-cycle vector table for the
// main sequences, then hand-written reset and interrupt sequences.

module tb_coproc_instr_sequencer;

  logic        clk;
  logic        reset_n;
  logic [1:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [31:0] writedata;
  logic [31:0] readdata;
  logic [5:0]  cp_instr;
  logic        cp_start;
  logic        cp_done;
  logic        irq;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic        wr;
    logic [1:0]  addr;
    logic [31:0] wdata;
    logic        done;
    logic [1:0]  raddr;
    logic        exp_start;
    logic [5:0]  exp_instr;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[$];

  coproc_instr_sequencer dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata),
    .cp_instr   (cp_instr),
    .cp_start   (cp_start),
    .cp_done    (cp_done),
    .irq        (irq)
  );

  // Clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input logic wr, input logic [1:0] addr, input logic [31:0] wdata,
                              input logic done, input logic [1:0] raddr, input logic es,
                              input logic [5:0] ei, input logic [31:0] er);
    vec_t t;
    t.wr = wr; t.addr = addr; t.wdata = wdata; t.done = done;
    t.raddr = raddr; t.exp_start = es; t.exp_instr = ei; t.exp_rd = er;
    vecs.push_back(t);
  endfunction

  function automatic void idle(input logic [1:0] raddr, input logic es, input logic [5:0] ei,
                               input logic [31:0] er);
    add(1'b0, 2'd0, 32'd0, 1'b0, raddr, es, ei, er);
  endfunction

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
    @(negedge clk);
    chipselect = 1'b1; write_n = 1'b0; address = a; writedata = d;
    @(posedge clk);
    #1;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  initial begin
    reset_n = 1'b0; chipselect = 1'b0; write_n = 1'b1;
    address = 2'd1; writedata = '0; cp_done = 1'b0;

    // Reset state
    idle(2'd1, 0, 6'h00, 32'h002);
    idle(2'd0, 0, 6'h00, 32'h000);
    idle(2'd2, 0, 6'h00, 32'h000);
    idle(2'd3, 0, 6'h00, 32'h000);
    // Single instruction 0x15 and its completion
    add(1, 2'd0, 32'h15, 0, 2'd1, 0, 6'h00, 32'h100);
    idle(2'd1, 1, 6'h15, 32'h003);
    idle(2'd1, 0, 6'h15, 32'h003);
    for (int i = 0; i < 3; i++) idle(2'd0, 0, 6'h15, 32'h015);
    add(0, 2'd0, 32'h0, 1, 2'd1, 0, 6'h15, 32'h022);
    idle(2'd3, 0, 6'h15, 32'h001);
    add(0, 2'd0, 32'h0, 1, 2'd3, 0, 6'h15, 32'h001);          // cp_done in IDLE ignored
    add(1, 2'd1, 32'h20, 0, 2'd1, 0, 6'h15, 32'h002);         // clear done_sticky
    add(1, 2'd3, 32'h0, 0, 2'd3, 0, 6'h15, 32'h000);          // clear count
    // Fill, overflow, in-order issue
    add(1, 2'd0, 32'h01, 0, 2'd1, 0, 6'h15, 32'h100);
    add(1, 2'd0, 32'h02, 0, 2'd1, 1, 6'h01, 32'h101);         // push+pop, count held
    add(1, 2'd0, 32'h03, 0, 2'd1, 0, 6'h01, 32'h201);
    add(1, 2'd0, 32'h04, 0, 2'd1, 0, 6'h01, 32'h301);
    add(1, 2'd0, 32'h05, 0, 2'd1, 0, 6'h01, 32'h405);
    add(1, 2'd0, 32'h06, 0, 2'd1, 0, 6'h01, 32'h40D);         // overflow
    add(1, 2'd1, 32'h01, 1, 2'd1, 0, 6'h01, 32'h424);         // done + clear errors
    add(1, 2'd0, 32'h07, 0, 2'd1, 1, 6'h02, 32'h329);         // push while full, pop same cycle
    idle(2'd0, 0, 6'h02, 32'h002);
    add(0, 2'd0, 32'h0, 1, 2'd1, 0, 6'h02, 32'h328);
    idle(2'd1, 1, 6'h03, 32'h229);
    idle(2'd1, 0, 6'h03, 32'h229);
    add(0, 2'd0, 32'h0, 1, 2'd0, 0, 6'h03, 32'h003);
    idle(2'd1, 1, 6'h04, 32'h129);
    idle(2'd1, 0, 6'h04, 32'h129);
    add(0, 2'd0, 32'h0, 1, 2'd1, 0, 6'h04, 32'h128);
    idle(2'd1, 1, 6'h05, 32'h02B);
    idle(2'd1, 0, 6'h05, 32'h02B);
    add(0, 2'd0, 32'h0, 1, 2'd1, 0, 6'h05, 32'h02A);
    idle(2'd3, 0, 6'h05, 32'h005);
    add(1, 2'd1, 32'h21, 0, 2'd1, 0, 6'h05, 32'h002);
    // Watchdog: limit 10, expiry then done-vs-expiry on the same edge
    add(1, 2'd2, 32'd10, 0, 2'd2, 0, 6'h05, 32'h00A);
    add(1, 2'd0, 32'h11, 0, 2'd1, 0, 6'h05, 32'h100);
    add(1, 2'd0, 32'h12, 0, 2'd1, 1, 6'h11, 32'h101);
    idle(2'd1, 0, 6'h11, 32'h101);                              // enter WAIT
    for (int i = 0; i < 9; i++) idle(2'd1, 0, 6'h11, 32'h101);
    idle(2'd1, 0, 6'h11, 32'h110);                              // 10th cycle: timeout
    idle(2'd1, 1, 6'h12, 32'h013);
    add(1, 2'd1, 32'h01, 0, 2'd1, 0, 6'h12, 32'h003);         // enter WAIT, clear err
    for (int i = 0; i < 9; i++) idle(2'd1, 0, 6'h12, 32'h003);
    add(1, 2'd1, 32'h20, 1, 2'd1, 0, 6'h12, 32'h022);         // done at expiry, set beats clear
    idle(2'd3, 0, 6'h12, 32'h006);
    // Flush during WAIT with 3 queued
    add(1, 2'd2, 32'd0, 0, 2'd2, 0, 6'h12, 32'h000);
    add(1, 2'd0, 32'h21, 0, 2'd1, 0, 6'h12, 32'h120);
    add(1, 2'd0, 32'h22, 0, 2'd1, 1, 6'h21, 32'h121);
    add(1, 2'd0, 32'h23, 0, 2'd1, 0, 6'h21, 32'h221);
    add(1, 2'd0, 32'h24, 0, 2'd1, 0, 6'h21, 32'h321);
    add(1, 2'd1, 32'h02, 0, 2'd1, 0, 6'h21, 32'h023);
    add(0, 2'd0, 32'h0, 1, 2'd1, 0, 6'h21, 32'h022);
    idle(2'd3, 0, 6'h21, 32'h007);
    idle(2'd0, 0, 6'h21, 32'h021);

    repeat (3) @(posedge clk);
    @(negedge clk);
    reset_n = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      vec_t v;
      v = vecs[i];
      @(negedge clk);
      chipselect = v.wr; write_n = ~v.wr; address = v.addr;
      writedata = v.wdata; cp_done = v.done;
      @(posedge clk);
      #1;
      chipselect = 1'b0; write_n = 1'b1; cp_done = 1'b0; address = v.raddr;
      #1;
      check($sformatf("step%0d cp_start", i), {31'd0, cp_start}, {31'd0, v.exp_start});
      check($sformatf("step%0d cp_instr", i), {26'd0, cp_instr}, {26'd0, v.exp_instr});
      check($sformatf("step%0d readdata", i), readdata, v.exp_rd);
      check($sformatf("step%0d irq", i), {31'd0, irq}, 32'd0);
    end

    // Reset asserted in WAIT with two queued
    bus_write(2'd0, 32'h31);
    bus_write(2'd0, 32'h32);
    bus_write(2'd0, 32'h33);
    address = 2'd1;
    #1;
    check("pre_reset status", readdata, 32'h221);
    #1;
    reset_n = 1'b0;
    #1;
    check("reset cp_start", {31'd0, cp_start}, 32'd0);
    check("reset cp_instr", {26'd0, cp_instr}, 32'd0);
    check("reset status", readdata, 32'h002);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    cp_done = 1'b1;
    @(posedge clk);
    #1;
    cp_done = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      check($sformatf("post_reset%0d cp_start", i), {31'd0, cp_start}, 32'd0);
    end
    check("post_reset status", readdata, 32'h002);
    address = 2'd3;
    #1;
    check("post_reset count", readdata, 32'h000);
    check("post_reset irq", {31'd0, irq}, 32'd0);

`ifdef COPROC_SEQ_IRQ_EN
    bus_write(2'd1, 32'h40);
    address = 2'd1;
    #1;
    check("irq_en status", readdata, 32'h042);
    check("irq before done", {31'd0, irq}, 32'd0);
    bus_write(2'd0, 32'h3A);
    repeat (2) @(posedge clk);
    @(negedge clk);
    cp_done = 1'b1;
    @(posedge clk);
    #1;
    cp_done = 1'b0;
    check("irq after done", {31'd0, irq}, 32'd1);
    bus_write(2'd1, 32'h60);
    #1;
    check("irq after clear", {31'd0, irq}, 32'd0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
